alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
Command sequencer directly upstream of the 16-bit ALU. It receives framed command bytes from the UART RX parallel interface and latches operands A/B and the function code. It pulses the ALU enable for exactly one cycle, captures the registered 16-bit result when OUT_Valid rises, and streams it to the UART TX as two bytes, low byte first, over a valid/ready handshake.

Parameters:
CMD_ALU_OP, 8'hCC, opcode for a frame carrying operands: CMD, A, B, FUN
CMD_ALU_NOP, 8'hDD, opcode for a frame reusing the stored A/B: CMD, FUN
TIMEOUT_CYCLES, 1024, idle cycles allowed between frame bytes (used only with the optional feature)

Ports:
CLK  in  1  system clock, all logic on the rising edge
RST  in  1  asynchronous, active-low reset
RX_P_DATA  in  8  received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
ALU_OUT  in  16  registered ALU result
OUT_Valid  in  1  ALU result valid
A  out  8  operand A to ALU
B  out  8  operand B to ALU
ALU_FUN  out  4  function code to ALU
ALU_EN  out  1  ALU enable, one-cycle pulse
TX_P_DATA  out  8  byte to transmit
TX_D_VLD  out  1  TX byte valid, held until accepted
TX_READY  in  1  TX accepts the byte when TX_D_VLD & TX_READY
BUSY  out  1  high in every state except IDLE
RX_DROP  out  1  one-cycle pulse when an RX byte is discarded

Behaviour:
- Reset (RST low, async): state IDLE; A=0, B=0, ALU_FUN=0, ALU_EN=0, TX_P_DATA=0, TX_D_VLD=0, RX_DROP=0, result register=0. Reset during any state aborts the frame silently.
- All outputs are registered.
- States: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LO, SEND_HI.
- IDLE, on RX_D_VLD:
  - byte==CMD_ALU_OP -> GET_A.
  - byte==CMD_ALU_NOP -> GET_FUN.
  - any other byte: stay in IDLE and pulse RX_DROP.
- GET_A: on RX_D_VLD, A<=byte, go to GET_B.
- GET_B: on RX_D_VLD, B<=byte, go to GET_FUN.
- GET_FUN: on RX_D_VLD, ALU_FUN<=byte[3:0] (bits 7:4 ignored), go to ALU_RUN.
- ALU_RUN: ALU_EN=1 for exactly this one cycle; next state WAIT_RES.
- WAIT_RES: on OUT_Valid==1, result<=ALU_OUT, go to SEND_LO.
  - Fixed latency: FUN byte strobe in cycle N, ALU_EN high in N+1, capture in N+3 (ALU output registered at end of N+1, OUT_Valid sampled in N+2).
- SEND_LO: TX_D_VLD=1, TX_P_DATA=result[7:0]. On TX_READY, go to SEND_HI.
- SEND_HI: TX_P_DATA=result[15:8]. On TX_READY, TX_D_VLD=0 and go to IDLE.
- TX_P_DATA stays stable while TX_D_VLD=1 and TX_READY=0.
- Consecutive transfers: back-to-back acceptance is allowed. TX_READY held high gives LO and HI on consecutive cycles.
- RX_D_VLD in ALU_RUN, WAIT_RES, SEND_LO or SEND_HI: byte discarded, RX_DROP pulses, state unaffected.
- A and B persist across frames until overwritten or reset, so a CMD_ALU_NOP frame reuses them. A CMD_ALU_NOP frame immediately after reset uses A=B=0.
- CMD_ALU_NOP and CMD_ALU_OP bytes received in GET_A, GET_B or GET_FUN are treated as data, not resync.
- ALU_FUN values 4'hF and any unsupported code are still executed; the ALU returns 0, and 16'h0000 is transmitted.

Optional Feature:
Macro ALU_CMD_TIMEOUT_EN.
- Defined:
  - A counter runs in GET_A, GET_B and GET_FUN, cleared on every RX_D_VLD and on state entry.
  - When it reaches TIMEOUT_CYCLES-1 without a byte, the FSM returns to IDLE and RX_DROP pulses once.
  - A, B and ALU_FUN keep whatever was already latched.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter; a partial frame waits indefinitely.

Decomposition:
- Package alu_cmd_pkg holds:
  - the state enum (3-bit encoding);
  - default opcode constants CMD_ALU_OP_DEF and CMD_ALU_NOP_DEF;
  - ALU function code constants: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, XNOR=9, EQ=A, GT=B, LT=C, SHR=D, SHL=E.
- Sub-module alu_cmd_tx_ser: 16-bit result to two-byte valid/ready serializer (SEND_LO/SEND_HI logic), reusable for other 16-bit responses.

Test Plan:
- Frame CC,05,03,00 (ADD) with TX_READY=1 -> ALU_EN single pulse one cycle after the FUN strobe; TX bytes 08 then 00; BUSY low afterwards.
- Frame CC,FF,FF,02 (MUL) with TX_READY low 5 cycles after TX_D_VLD rises -> TX_P_DATA holds 01 stable until accepted, then FE (result FE01).
- After the previous frame, send DD,01 (SUB) -> 0000 transmitted; then DD,0B (GT) with stored A=B=FF -> 0000; then CC,09,04,0B -> 0002.
- Byte 55 in IDLE and a byte during WAIT_RES -> RX_DROP pulses each time, no ALU_EN, state unaffected.
- RST asserted in SEND_HI -> all outputs 0 asynchronously, state IDLE; the next frame CC,02,02,0A returns 0001.
- With ALU_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send CC,07 then stall 16 cycles -> return to IDLE with RX_DROP; a subsequent DD,00 transmits 0007 (A=07, B=00 at reset).

Source files
------------

// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The state encoding, the default opcodes and the ALU function codes live here.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_FUN  = 3'd3,
        ST_ALU_RUN  = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_SEND_LO  = 3'd6,
        ST_SEND_HI  = 3'd7
    } state_t;

    localparam logic [7:0] CMD_ALU_OP_DEF     = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP_DEF    = 8'hDD;
    localparam int         TIMEOUT_CYCLES_DEF = 1024;

    localparam logic [3:0] FUN_ADD  = 4'h0;
    localparam logic [3:0] FUN_SUB  = 4'h1;
    localparam logic [3:0] FUN_MUL  = 4'h2;
    localparam logic [3:0] FUN_DIV  = 4'h3;
    localparam logic [3:0] FUN_AND  = 4'h4;
    localparam logic [3:0] FUN_OR   = 4'h5;
    localparam logic [3:0] FUN_NAND = 4'h6;
    localparam logic [3:0] FUN_NOR  = 4'h7;
    localparam logic [3:0] FUN_XOR  = 4'h8;
    localparam logic [3:0] FUN_XNOR = 4'h9;
    localparam logic [3:0] FUN_EQ   = 4'hA;
    localparam logic [3:0] FUN_GT   = 4'hB;
    localparam logic [3:0] FUN_LT   = 4'hC;
    localparam logic [3:0] FUN_SHR  = 4'hD;
    localparam logic [3:0] FUN_SHL  = 4'hE;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and its neighbours:
// UART RX parallel side, the ALU, and the UART TX valid/ready side.
interface alu_cmd_ctrl_if;

    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] ALU_OUT;
    logic        OUT_Valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_READY;
    logic        BUSY;
    logic        RX_DROP;

    // The sequencer itself
    modport master (
        input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, TX_READY,
        output A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY, RX_DROP
    );

    // The surrounding RX / ALU / TX blocks
    modport slave (
        output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_Valid, TX_READY,
        input  A, B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, BUSY, RX_DROP
    );

endinterface

// File: rtl/alu_cmd_tx_ser.sv
// Two-byte serializer: takes a 16-bit word on load and offers it low byte
// first over a valid/ready handshake. Byte data is held stable until accepted.
module alu_cmd_tx_ser (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    output logic        lo_done,
    output logic        hi_done
);

    logic [7:0] result_hi_q;
    logic       hi_q;
    logic       accept;

    assign accept  = tx_vld & tx_ready;
    assign lo_done = accept & ~hi_q;
    assign hi_done = accept & hi_q;

    // Load the word, then step from low byte to high byte on each acceptance
    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result_hi_q <= '0;
            hi_q        <= 1'b0;
            tx_vld      <= 1'b0;
            tx_data     <= '0;
        end else if (load) begin
            result_hi_q <= data[15:8];
            hi_q        <= 1'b0;
            tx_vld      <= 1'b1;
            tx_data     <= data[7:0];
        end else if (lo_done) begin
            hi_q    <= 1'b1;
            tx_data <= result_hi_q;
        end else if (hi_done) begin
            hi_q   <= 1'b0;
            tx_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer in front of the 16-bit ALU: parses CC/DD frames from
// UART RX, pulses ALU_EN once, captures the result and sends it low byte first.
// Optional macro ALU_CMD_TIMEOUT_EN: abandons a partial frame after
// TIMEOUT_CYCLES idle cycles between bytes.
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
#(
    parameter logic [7:0] CMD_ALU_OP  = CMD_ALU_OP_DEF,
    parameter logic [7:0] CMD_ALU_NOP = CMD_ALU_NOP_DEF
`ifdef ALU_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic          CLK,
    input  logic          RST,
    alu_cmd_ctrl_if.master bus
);

    state_t state_q;
    state_t state_d;
    logic   drop_d;
    logic   timeout;
    logic   load_res;
    logic   lo_done;
    logic   hi_done;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] gap_cnt_q;
    logic             in_frame;

    assign in_frame = (state_q == ST_GET_A) || (state_q == ST_GET_B) || (state_q == ST_GET_FUN);
    assign timeout  = in_frame && !bus.RX_D_VLD && (gap_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count idle cycles between frame bytes; any byte or leaving the frame clears it
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gap_cnt_q <= '0;
        end else if (in_frame && !bus.RX_D_VLD && !timeout) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
        end else begin
            gap_cnt_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign load_res = (state_q == ST_WAIT_RES) && bus.OUT_Valid;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and drop decision
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        drop_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_ALU_OP) begin
                        state_d = ST_GET_A;
                    end else if (bus.RX_P_DATA == CMD_ALU_NOP) begin
                        state_d = ST_GET_FUN;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (bus.RX_D_VLD) begin
                    state_d = ST_GET_B;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end
            end
            ST_GET_B: begin
                if (bus.RX_D_VLD) begin
                    state_d = ST_GET_FUN;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end
            end
            ST_GET_FUN: begin
                if (bus.RX_D_VLD) begin
                    state_d = ST_ALU_RUN;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end
            end
            ST_ALU_RUN: begin
                state_d = ST_WAIT_RES;
                drop_d  = bus.RX_D_VLD;
            end
            ST_WAIT_RES: begin
                if (bus.OUT_Valid) state_d = ST_SEND_LO;
                drop_d = bus.RX_D_VLD;
            end
            ST_SEND_LO: begin
                if (lo_done) state_d = ST_SEND_HI;
                drop_d = bus.RX_D_VLD;
            end
            ST_SEND_HI: begin
                if (hi_done) state_d = ST_IDLE;
                drop_d = bus.RX_D_VLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs: operand/function latches, enable pulse, busy and drop
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.A       <= '0;
            bus.B       <= '0;
            bus.ALU_FUN <= '0;
            bus.ALU_EN  <= 1'b0;
            bus.BUSY    <= 1'b0;
            bus.RX_DROP <= 1'b0;
        end else begin
            bus.ALU_EN  <= (state_d == ST_ALU_RUN);
            bus.BUSY    <= (state_d != ST_IDLE);
            bus.RX_DROP <= drop_d;
            if (bus.RX_D_VLD) begin
                case (state_q)
                    ST_GET_A:   bus.A       <= bus.RX_P_DATA;
                    ST_GET_B:   bus.B       <= bus.RX_P_DATA;
                    ST_GET_FUN: bus.ALU_FUN <= bus.RX_P_DATA[3:0];
                    default:    ;
                endcase
            end
        end
    end

    alu_cmd_tx_ser u_tx_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load_res),
        .data     (bus.ALU_OUT),
        .tx_ready (bus.TX_READY),
        .tx_data  (bus.TX_P_DATA),
        .tx_vld   (bus.TX_D_VLD),
        .lo_done  (lo_done),
        .hi_done  (hi_done)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: directed frames, reset abort,
// optional timeout (ALU_CMD_TIMEOUT_EN) and randomized frames checked against
// a frame-level reference model. A registered ALU model sits beside the DUT.
`timescale 1ns/1ps
module tb_alu_cmd_ctrl;
    import alu_cmd_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    alu_cmd_ctrl_if bus ();

`ifdef ALU_CMD_TIMEOUT_EN
    alu_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
`else
    alu_cmd_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));
`endif

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ALU behaviour: 16-bit result of the 8-bit operands; unsupported codes give 0
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (fun)
            FUN_ADD:  return wa + wb;
            FUN_SUB:  return wa - wb;
            FUN_MUL:  return wa * wb;
            FUN_DIV:  return (b == 8'h00) ? 16'h0000 : wa / wb;
            FUN_AND:  return wa & wb;
            FUN_OR:   return wa | wb;
            FUN_NAND: return {8'h00, ~(a & b)};
            FUN_NOR:  return {8'h00, ~(a | b)};
            FUN_XOR:  return wa ^ wb;
            FUN_XNOR: return {8'h00, ~(a ^ b)};
            FUN_EQ:   return (a == b) ? 16'd1 : 16'd0;
            FUN_GT:   return (a > b)  ? 16'd2 : 16'd0;
            FUN_LT:   return (a < b)  ? 16'd3 : 16'd0;
            FUN_SHR:  return wa >> 1;
            FUN_SHL:  return wa << 1;
            default:  return 16'h0000;
        endcase
    endfunction

    // Registered ALU next to the DUT: result and valid one cycle after ALU_EN
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.ALU_OUT   <= '0;
            bus.OUT_Valid <= 1'b0;
        end else begin
            bus.OUT_Valid <= bus.ALU_EN;
            if (bus.ALU_EN) bus.ALU_OUT <= alu_ref(bus.A, bus.B, bus.ALU_FUN);
        end
    end

    // Reference model: frame parse position and stored operands
    int          m_pos = 0;   // 0 idle, 1 want A, 2 want B, 3 want FUN, 4 executing/sending
    logic [7:0]  m_a = 8'h00;
    logic [7:0]  m_b = 8'h00;
    logic [3:0]  m_fun = 4'h0;
    logic [7:0]  exp_bytes[$];
    int          en_q[$];
    int          drop_q[$];

    // Monitor-owned progress counters
    int acc_cnt  = 0;
    int en_idx   = 0;
    int drop_idx = 0;

    bit rnd_ready = 1'b0;

    function automatic void model_byte(input logic [7:0] b);
        logic [15:0] r;
        if (m_pos == 4 && acc_cnt == exp_bytes.size()) m_pos = 0;
        case (m_pos)
            0: begin
                if (b == CMD_ALU_OP_DEF)       m_pos = 1;
                else if (b == CMD_ALU_NOP_DEF) m_pos = 3;
                else                           drop_q.push_back(cyc + 1);
            end
            1: begin m_a = b; m_pos = 2; end
            2: begin m_b = b; m_pos = 3; end
            3: begin
                m_fun = b[3:0];
                m_pos = 4;
                en_q.push_back(cyc + 1);
                r = alu_ref(m_a, m_b, m_fun);
                exp_bytes.push_back(r[7:0]);
                exp_bytes.push_back(r[15:8]);
            end
            default: drop_q.push_back(cyc + 1);
        endcase
    endfunction

    // Sample outputs on the falling edge, away from the active edge
    always @(negedge CLK) begin : monitor
        logic exp_en;
        logic exp_drop;
        if (RST) begin
            exp_en = (en_idx < en_q.size()) && (en_q[en_idx] == cyc);
            if (exp_en) en_idx <= en_idx + 1;
            check("alu_en", bus.ALU_EN, exp_en);
            if (exp_en) begin
                check("op_a", bus.A, m_a);
                check("op_b", bus.B, m_b);
                check("op_fun", bus.ALU_FUN, m_fun);
            end
            exp_drop = (drop_idx < drop_q.size()) && (drop_q[drop_idx] == cyc);
            if (exp_drop) drop_idx <= drop_idx + 1;
            check("rx_drop", bus.RX_DROP, exp_drop);
            if (bus.TX_D_VLD) begin
                if (acc_cnt >= exp_bytes.size()) begin
                    check("tx_spurious", bus.TX_D_VLD, 1'b0);
                end else begin
                    check("tx_byte", bus.TX_P_DATA, exp_bytes[acc_cnt]);
                    if (bus.TX_READY) acc_cnt <= acc_cnt + 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            if (rnd_ready) bus.TX_READY = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        model_byte(b);
        tick(1);
        bus.RX_D_VLD  = 1'b0;
    endtask

    // Sends a frame; busy_dly > 0 also sends a stray byte busy_dly cycles after FUN
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] fun, input int busy_dly);
        send_byte(cmd);
        if (cmd == CMD_ALU_OP_DEF) begin
            send_byte(a);
            send_byte(b);
        end
        send_byte(fun);
        if (busy_dly > 0) begin
            tick(busy_dly - 1);
            send_byte(8'h5A);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (acc_cnt != exp_bytes.size() && n < 300) begin
            tick(1);
            n++;
        end
        check("idle_wait", acc_cnt, exp_bytes.size());
        check("busy_idle", bus.BUSY, 1'b0);
    endtask

    task automatic wait_tx_vld();
        int n;
        n = 0;
        while (!bus.TX_D_VLD && n < 20) begin
            tick(1);
            n++;
        end
        check("tx_vld_wait", bus.TX_D_VLD, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"},    bus.A, 8'h00);
        check({tag, "_b"},    bus.B, 8'h00);
        check({tag, "_fun"},  bus.ALU_FUN, 4'h0);
        check({tag, "_en"},   bus.ALU_EN, 1'b0);
        check({tag, "_txd"},  bus.TX_P_DATA, 8'h00);
        check({tag, "_txv"},  bus.TX_D_VLD, 1'b0);
        check({tag, "_busy"}, bus.BUSY, 1'b0);
        check({tag, "_drop"}, bus.RX_DROP, 1'b0);
    endtask

    // Abort any pending response and return the model to its reset state
    task automatic do_reset();
        #2;
        RST = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        while (exp_bytes.size() > acc_cnt) void'(exp_bytes.pop_back());
        m_pos = 0;
        m_a   = 8'h00;
        m_b   = 8'h00;
        m_fun = 4'h0;
        tick(2);
        RST = 1'b1;
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int kind;
        bus.RX_P_DATA = 8'h00;
        bus.RX_D_VLD  = 1'b0;
        bus.TX_READY  = 1'b1;

        tick(3);
        check_reset_outputs("rst_init");
        RST = 1'b1;
        tick(2);

        // ADD 05+03 with TX always ready
        send_frame(8'hCC, 8'h05, 8'h03, 8'h00, 0);
        check("busy_run", bus.BUSY, 1'b1);
        wait_idle();

        // MUL FF*FF with TX stalled five cycles: low byte must hold
        bus.TX_READY = 1'b0;
        send_frame(8'hCC, 8'hFF, 8'hFF, 8'h02, 0);
        wait_tx_vld();
        tick(5);
        check("hold_vld", bus.TX_D_VLD, 1'b1);
        bus.TX_READY = 1'b1;
        wait_idle();

        // Reuse of stored operands, then a fresh GT frame
        send_frame(8'hDD, 8'h00, 8'h00, 8'h01, 0);
        wait_idle();
        send_frame(8'hDD, 8'h00, 8'h00, 8'h0B, 0);
        wait_idle();
        send_frame(8'hCC, 8'h09, 8'h04, 8'h0B, 0);
        wait_idle();

        // Junk in IDLE and a stray byte during WAIT_RES
        send_byte(8'h55);
        tick(2);
        send_frame(8'hDD, 8'h00, 8'h00, 8'h00, 2);
        wait_idle();

        // Reset while the high byte is pending
        bus.TX_READY = 1'b0;
        send_frame(8'hCC, 8'h12, 8'h34, 8'h02, 0);
        wait_tx_vld();
        bus.TX_READY = 1'b1;
        tick(1);
        bus.TX_READY = 1'b0;
        check("in_send_hi", bus.TX_D_VLD, 1'b1);
        do_reset();
        bus.TX_READY = 1'b1;
        tick(1);
        send_frame(8'hCC, 8'h02, 8'h02, 8'h0A, 0);
        wait_idle();

`ifdef ALU_CMD_TIMEOUT_EN
        // Partial frame abandoned after 16 idle cycles; A keeps 07, B is 00
        tick(1);
        do_reset();
        tick(1);
        send_byte(8'hCC);
        send_byte(8'h07);
        drop_q.push_back(cyc + 16);
        m_pos = 0;
        tick(14);
        check("to_busy", bus.BUSY, 1'b1);
        tick(6);
        check("to_idle", bus.BUSY, 1'b0);
        send_frame(8'hDD, 8'h00, 8'h00, 8'h00, 0);
        wait_idle();
`endif

        // Randomized frames with random TX backpressure and stray bytes
        rnd_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                b0 = 8'($urandom_range(0, 255));
                if (b0 == CMD_ALU_OP_DEF || b0 == CMD_ALU_NOP_DEF) b0 = 8'h55;
                send_byte(b0);
                tick($urandom_range(0, 2));
            end else begin
                b0 = ($urandom_range(0, 7) == 0) ? CMD_ALU_NOP_DEF : 8'($urandom_range(0, 255));
                b1 = ($urandom_range(0, 7) == 0) ? CMD_ALU_OP_DEF  : 8'($urandom_range(0, 255));
                b2 = 8'($urandom_range(0, 255));
                send_byte((kind < 7) ? CMD_ALU_OP_DEF : CMD_ALU_NOP_DEF);
                tick($urandom_range(0, 2));
                if (kind < 7) begin
                    send_byte(b0);
                    tick($urandom_range(0, 2));
                    send_byte(b1);
                    tick($urandom_range(0, 2));
                end
                send_byte(b2);
                if ($urandom_range(0, 2) == 0) begin
                    tick($urandom_range(0, 3));
                    send_byte(8'($urandom_range(0, 255)));
                end
                wait_idle();
            end
        end
        rnd_ready = 1'b0;
        bus.TX_READY = 1'b1;

        tick(5);
        check("en_all_seen", en_idx, en_q.size());
        check("drop_all_seen", drop_idx, drop_q.size());
        check("tx_all_seen", acc_cnt, exp_bytes.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
